// File: rtl/crossbar_ingress_queue.sv
// Store-and-forward ingress frame queue feeding the crossbar output arbiters.
// Buffers whole frames, requests the destination output and streams on grant.
module crossbar_ingress_queue #(
  parameter int unsigned P_PORTS  = 3,
  parameter int unsigned P_DATA_W = 8,
  parameter int unsigned P_DEPTH  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [P_DATA_W-1:0] in_data_i,
  input  logic                in_last_i,
  input  logic [P_PORTS-1:0]  in_dest_i,
  output logic [P_PORTS-1:0]  request_o,
  input  logic [P_PORTS-1:0]  grant_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [P_DATA_W-1:0] out_data_o,
  output logic                out_last_o,
  output logic [15:0]         drop_cnt_o
);

  localparam int unsigned AW = $clog2(P_DEPTH);

  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StReq, StXfer, StDrop} state_e;

  logic [P_DATA_W:0]  data_mem [P_DEPTH];
  logic [P_PORTS-1:0] dest_mem [P_DEPTH];

  ptr_t   wr_ptr_q, rd_ptr_q, dwr_ptr_q, drd_ptr_q;
  ptr_t   frame_cnt_q;
  logic   sop_q;
  logic [15:0] drop_cnt_q;
  state_e state_q, state_d;

  logic               full, push, desc_push, pop, desc_pop, drop_inc;
  logic               one_hot, granted;
  logic [P_DATA_W:0]  head;
  logic [P_PORTS-1:0] head_dest;

  assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign in_ready_o = ~full;
  assign push       = in_valid_i & ~full;
  assign desc_push  = push & sop_q;

  assign head       = data_mem[rd_ptr_q[AW-1:0]];
  assign out_data_o = head[P_DATA_W-1:0];
  assign out_last_o = head[P_DATA_W];
  assign head_dest  = dest_mem[drd_ptr_q[AW-1:0]];
  assign one_hot    = (head_dest != '0) && ((head_dest & (head_dest - 1'b1)) == '0);
  assign granted    = |(grant_i & head_dest);
  assign drop_cnt_o = drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q[AW-1:0]] <= {in_last_i, in_data_i};
    end
    if (desc_push) begin
      dest_mem[dwr_ptr_q[AW-1:0]] <= in_dest_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    request_o   = '0;
    out_valid_o = 1'b0;
    pop         = 1'b0;
    desc_pop    = 1'b0;
    drop_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_cnt_q != '0) begin
          state_d = one_hot ? StReq : StDrop;
        end
      end
      StReq: begin
        request_o = head_dest;
        if (granted) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        request_o   = head_dest;
        out_valid_o = granted;
        pop         = granted & out_ready_i;
        // Release the request on the last pop so the holding arbiter can rotate now.
        if (pop && out_last_o) begin
          request_o = '0;
          desc_pop  = 1'b1;
          state_d   = StIdle;
        end
      end
      StDrop: begin
        pop = 1'b1;
        if (out_last_o) begin
          desc_pop = 1'b1;
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dwr_ptr_q   <= '0;
      drd_ptr_q   <= '0;
      frame_cnt_q <= '0;
      sop_q       <= 1'b1;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        sop_q    <= in_last_i;
      end
      if (desc_push) begin
        dwr_ptr_q <= dwr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (desc_pop) begin
        drd_ptr_q <= drd_ptr_q + 1'b1;
      end
      // desc_pop marks the last beat of a frame leaving, delivered or dropped.
      case ({push & in_last_i, desc_pop})
        2'b10:   frame_cnt_q <= frame_cnt_q + 1'b1;
        2'b01:   frame_cnt_q <= frame_cnt_q - 1'b1;
        default: frame_cnt_q <= frame_cnt_q;
      endcase
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

endmodule
